// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 device-to-host frame receiver with glitch filter, timeout and byte FIFO.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   raw PS/2 lines, asynchronous to clk
//   data, valid, ready  FIFO head byte with valid/ready pop handshake
//   count               bytes currently held in the FIFO
//   parity_err          one-cycle pulse, frame dropped on bad parity
//   frame_err           one-cycle pulse, frame dropped on bad stop bit or timeout
//   overflow            one-cycle pulse, good byte dropped because FIFO full
module ps2_receiver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    data,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2, filt, filt_d, sample;
    logic [FW-1:0] filt_cnt;
    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          push, push_n, parity_err_n, frame_err_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop, full, wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            filt_d <= filt;
            if (clk_s2 == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt     <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign sample = filt_d & ~filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            push       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            to_cnt     <= to_cnt_n;
            push       <= push_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        par_n        = par;
        to_cnt_n     = (state == IDLE || sample) ? '0 : to_cnt + 1'b1;
        push_n       = 1'b0;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;
        if (state != IDLE && !sample && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_n     = IDLE;
            bit_cnt_n   = '0;
            shreg_n     = '0;
            to_cnt_n    = '0;
            frame_err_n = 1'b1;
        end else if (sample) begin
            case (state)
                IDLE: begin
                    state_n   = dat_s2 ? IDLE : DATA;
                    bit_cnt_n = '0;
                end
                DATA: begin
                    shreg_n   = {dat_s2, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = (bit_cnt == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                STOP: begin
                    // shreg is held in IDLE, so the push cycle still sees the byte
                    state_n      = IDLE;
                    frame_err_n  = ~dat_s2;
                    push_n       = dat_s2 & ^{shreg, par};
                    parity_err_n = dat_s2 & ~^{shreg, par};
                end
            endcase
        end
    end

    assign pop      = valid & ready;
    assign full     = cnt == CW'(FIFO_DEPTH);
    assign wr_en    = push & (~full | pop);
    assign overflow = push & full & ~pop;
    assign valid    = cnt != '0;
    assign data     = valid ? mem[rd_ptr] : 8'h00;
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(pop);
            cnt    <= cnt + CW'(wr_en) - CW'(pop);
        end
    end
endmodule

// File: doc/ps2_receiver.md
PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, received-byte buffer depth (power of two, >=2).
REQ-002 Parameter FILTER_LEN, default 8, consecutive equal system-clock samples required to accept a ps2_clk level change.
REQ-003 Parameter TIMEOUT_CYCLES, default 10000, system-clock cycles without a ps2_clk falling edge before an in-progress frame is aborted.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  system clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-008 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-009 data  output  8  byte at FIFO head.
REQ-010 valid  output  1  FIFO non-empty; data is meaningful.
REQ-011 ready  input  1  consumer accepts head when valid&&ready.
REQ-012 count  output  $clog2(FIFO_DEPTH)+1  bytes held.
REQ-013 parity_err  output  1  one-cycle pulse, frame dropped on bad parity.
REQ-014 frame_err  output  1  one-cycle pulse, frame dropped on bad stop bit or timeout.
REQ-015 overflow  output  1  one-cycle pulse, good byte dropped because FIFO full.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before use.
REQ-017 Filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; filtered clock resets to 1.
REQ-018 A sample event SHALL be a 1->0 transition of the filtered clock; synchronized ps2_data is sampled in that cycle.
REQ-019 FSM states: IDLE, DATA, PARITY, STOP.
REQ-020 IDLE: sample event with data=0 -> DATA, bit counter=0; sample with data=1 ignored, stay IDLE.
REQ-021 DATA: each sample shifts in LSB first; after the 8th bit -> PARITY.
REQ-022 PARITY: capture bit -> STOP.
REQ-023 STOP: on sample event, always -> IDLE; stop=1 and odd parity (ones in 8 data bits + parity bit odd) -> push byte; stop=0 -> frame_err; stop=1 with even parity -> parity_err. frame_err takes precedence when both are bad.
REQ-024 Timeout counter SHALL reset on every sample event and in IDLE; reaching TIMEOUT_CYCLES in DATA/PARITY/STOP -> frame_err pulse, discard partial byte, -> IDLE.
REQ-025 Error/overflow pulses and the push SHALL occur in the cycle after the STOP sample-event cycle (or the timeout cycle).
REQ-026 Pushed byte SHALL appear on data with valid=1 one cycle after the push when the FIFO was empty.
REQ-027 Pop occurs on the clock edge where valid&&ready; ready while valid=0 has no effect.
REQ-028 Push with count==FIFO_DEPTH and no pop: byte dropped, overflow pulse, contents unchanged.
REQ-029 Simultaneous push and pop when full: both performed, no overflow, count unchanged.
REQ-030 Simultaneous push and pop otherwise: count unchanged, FIFO order preserved.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH.

Reset
REQ-032 rst_n=0 SHALL immediately force: FSM=IDLE, bit/timeout counters=0, FIFO empty, count=0, valid=0, data=8'h00, all pulses 0, synchronizers and filtered clock=1.
REQ-033 Reset mid-frame SHALL discard the partial frame; the next frame starting after release SHALL be received normally.

Verification
REQ-034 Frame start=0, byte 0xA2 LSB first, parity=0, stop=1, 10 kHz ps2_clk -> valid=1, data=0xA2, count=1, no error pulses.
REQ-035 Same frame with parity=1 -> parity_err single pulse, valid stays 0, count=0.
REQ-036 Frame with stop=0 -> frame_err pulse; next good frame 0x1C (parity 0) -> data=0x1C.
REQ-037 Send 5 good bytes 0x01..0x05 with ready=0, FIFO_DEPTH=4 -> count=4, overflow pulse on 5th; popping yields 0x01,0x02,0x03,0x04.
REQ-038 Stop ps2_clk after 4 data bits for > TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; following 0xA2 frame received correctly.
REQ-039 Glitch on ps2_clk low for FILTER_LEN-1 cycles mid-frame -> no sample event; byte still received intact.
